// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory subsystem controller.
// FSM state encoding, default bus geometry and the round-robin pick.
package mem_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 9;
    localparam int MAX_CH         = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } mem_state_e;

    // First requesting channel at or after 'start', wrapping modulo num_ch.
    // Scanned from the far end so the nearest hit is the last one assigned.
    function automatic int rr_next(input logic [MAX_CH-1:0] req, input int start, input int num_ch);
        int win;
        int idx;
        win = start;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (i < num_ch) begin
                idx = (start + i) % num_ch;
                if (req[idx]) win = idx;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_subsystem_ctrl_if.sv
// Requester-side bus of the memory subsystem controller.
// Channel i occupies slice [i*W +: W] of the flattened addr/wdata vectors.
interface mem_subsystem_ctrl_if #(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]            req;
    logic [NUM_CH-1:0]            we;
    logic [NUM_CH*ADDR_WIDTH-1:0] addr;
    logic [NUM_CH*DATA_WIDTH-1:0] wdata;
    logic [NUM_CH-1:0]            ready;
    logic [DATA_WIDTH-1:0]        rdata;
    logic                         busy;
    logic [CH_W-1:0]              grant_ch;

    modport master (output req, we, addr, wdata, input ready, rdata, busy, grant_ch);
    modport slave  (input req, we, addr, wdata, output ready, rdata, busy, grant_ch);
endinterface

// File: rtl/ram_sp_sync.sv
// Single-port synchronous RAM, registered read, write-first.
// With MEM_PRELOAD_EN defined a side write port exists; it is applied
// after the main port so it wins on an address collision.
module ram_sp_sync #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
`ifdef MEM_PRELOAD_EN
    ,
    input  logic                  pl_en,
    input  logic [ADDR_WIDTH-1:0] pl_addr,
    input  logic [DATA_WIDTH-1:0] pl_data
`endif
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] dout_q;

    // Array access; contents deliberately have no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
                dout_q    <= din;
            end else begin
                dout_q    <= mem[addr];
            end
        end
`ifdef MEM_PRELOAD_EN
        if (pl_en) mem[pl_addr] <= pl_data;
`endif
    end

    assign dout = dout_q;
endmodule

// File: rtl/mem_subsystem_ctrl.sv
// Round-robin arbiter + wait-state sequencer in front of ram_sp_sync.
// Optional feature macro: MEM_PRELOAD_EN (adds a preload write port).
module mem_subsystem_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int NUM_CH      = 2,
    parameter int WAIT_STATES = 1
) (
    input logic                 Clock,
    input logic                 clear,
    mem_subsystem_ctrl_if.slave bus
`ifdef MEM_PRELOAD_EN
    ,
    input logic                  preload_en,
    input logic [ADDR_WIDTH-1:0] preload_addr,
    input logic [DATA_WIDTH-1:0] preload_data
`endif
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    mem_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [CH_W-1:0]       rr_q, rr_d;
    logic [CH_W-1:0]       grant_q, grant_d;
    logic                  we_lat_q, we_lat_d;
    logic [ADDR_WIDTH-1:0] addr_lat_q, addr_lat_d;
    logic [DATA_WIDTH-1:0] wdata_lat_q, wdata_lat_d;
    logic [NUM_CH-1:0]     ready_q, ready_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  busy_q, busy_d;

    logic [NUM_CH-1:0]     req_eff;
    logic [DATA_WIDTH-1:0] ram_dout;

    // A channel whose ready is pulsing this cycle is still holding req from
    // the access just finished; mask it so it is not granted twice.
    assign req_eff = bus.req & ~ready_q;

    // Next-state and registered-output computation for the sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        we_lat_d    = we_lat_q;
        addr_lat_d  = addr_lat_q;
        wdata_lat_d = wdata_lat_q;
        ready_d     = '0;
        rdata_d     = '0;
        case (state_q)
            IDLE: begin
                if (|req_eff) begin
                    grant_d     = CH_W'(rr_next(MAX_CH'(req_eff), int'(rr_q), NUM_CH));
                    we_lat_d    = bus.we[grant_d];
                    addr_lat_d  = bus.addr[grant_d*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_lat_d = bus.wdata[grant_d*DATA_WIDTH +: DATA_WIDTH];
                    cnt_d       = 4'(WAIT_STATES);
                    state_d     = (WAIT_STATES == 0) ? COMMIT : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = COMMIT;
            end
            COMMIT: begin
                // rr pointer holds the first channel to consider next time.
                rr_d    = CH_W'((int'(grant_q) + 1) % NUM_CH);
                state_d = DONE;
            end
            DONE: begin
                ready_d[grant_q] = 1'b1;
                rdata_d          = we_lat_q ? '0 : ram_dout;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Sequencer state; reset aborts any access in flight.
    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rr_q        <= '0;
            grant_q     <= '0;
            we_lat_q    <= 1'b0;
            addr_lat_q  <= '0;
            wdata_lat_q <= '0;
            ready_q     <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            we_lat_q    <= we_lat_d;
            addr_lat_q  <= addr_lat_d;
            wdata_lat_q <= wdata_lat_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
        end
    end

    ram_sp_sync #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (Clock),
        .en      (state_q == COMMIT),
        .we      (we_lat_q),
        .addr    (addr_lat_q),
        .din     (wdata_lat_q),
        .dout    (ram_dout)
`ifdef MEM_PRELOAD_EN
        ,
        .pl_en   (preload_en),
        .pl_addr (preload_addr),
        .pl_data (preload_data)
`endif
    );

    assign bus.ready    = ready_q;
    assign bus.rdata    = rdata_q;
    assign bus.busy     = busy_q;
    assign bus.grant_ch = grant_q;
endmodule

// File: tb/tb_mem_subsystem_ctrl.sv
// Scoreboard bench for mem_subsystem_ctrl: stimulus pushes the expected
// (channel, rdata) of each access; a negedge monitor pops on every ready.
module tb_mem_subsystem_ctrl;
    localparam int DW = 32;
    localparam int AW = 9;
    localparam int NC = 2;

    typedef struct {
        int          ch;
        logic [31:0] data;
    } exp_t;

    logic Clock = 1'b0;
    logic clear = 1'b1;
    logic          preload_en   = 1'b0;
    logic [AW-1:0] preload_addr = '0;
    logic [DW-1:0] preload_data = '0;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    always #5 Clock = ~Clock;

    mem_subsystem_ctrl_if #(.NUM_CH(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    mem_subsystem_ctrl_if #(.NUM_CH(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    mem_subsystem_ctrl_if #(.NUM_CH(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus15 ();

    mem_subsystem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC), .WAIT_STATES(1)) dut (
        .Clock (Clock), .clear (clear), .bus (bus)
`ifdef MEM_PRELOAD_EN
        , .preload_en (preload_en), .preload_addr (preload_addr), .preload_data (preload_data)
`endif
    );
    mem_subsystem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC), .WAIT_STATES(0)) dut_ws0 (
        .Clock (Clock), .clear (clear), .bus (bus0)
`ifdef MEM_PRELOAD_EN
        , .preload_en (1'b0), .preload_addr (preload_addr), .preload_data (preload_data)
`endif
    );
    mem_subsystem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC), .WAIT_STATES(15)) dut_ws15 (
        .Clock (Clock), .clear (clear), .bus (bus15)
`ifdef MEM_PRELOAD_EN
        , .preload_en (1'b0), .preload_addr (preload_addr), .preload_data (preload_data)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Issue one access on channel ch; caller is just after a rising edge.
    // Returns rising edges from req to the cycle ready is seen.
    task automatic issue(input int ch, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int lat);
        bit seen = 0;
        bus.we[ch] = w;
        bus.addr[ch*AW +: AW] = a;
        bus.wdata[ch*DW +: DW] = d;
        bus.req[ch] = 1'b1;
        lat = 0;
        while (lat < 40 && !seen) begin
            @(posedge Clock);
            lat++;
            @(negedge Clock);
            if (bus.ready[ch]) seen = 1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout ch%0d: got no ready expected ready", ch);
        end
        @(posedge Clock);
        #1;
        bus.req[ch] = 1'b0;
    endtask

    task automatic do_reset();
        clear = 1'b1;
        @(posedge Clock);
        #1;
        clear = 1'b0;
    endtask

    // Monitor: every ready pulse must match the head of the scoreboard.
    always @(negedge Clock) begin
        if (bus.ready != '0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ready: got ready=%b expected none", bus.ready);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (!bus.ready[e.ch] || $countones(bus.ready) != 1 || bus.rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL ready_ch%0d: got ready=%b rdata=%0h expected ch%0d rdata=%0h",
                             e.ch, bus.ready, bus.rdata, e.ch, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, l1, lat, lat0, lat15;
        bit got;
        bus.req = '0;   bus.we = '0;   bus.addr = '0;   bus.wdata = '0;
        bus0.req = '0;  bus0.we = '0;  bus0.addr = '0;  bus0.wdata = '0;
        bus15.req = '0; bus15.we = '0; bus15.addr = '0; bus15.wdata = '0;
        repeat (2) @(posedge Clock);
        #1;
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_ready", 32'(bus.ready), 0);
        chk("reset_rdata", bus.rdata, 0);
        chk("reset_grant", 32'(bus.grant_ch), 0);
        clear = 1'b0;

        // Old value at 0x010, then a write aborted by reset mid-WAIT.
        exp_q.push_back('{0, 32'h0});
        issue(0, 1'b1, 9'h010, 32'h0BADF00D, l0);
        bus.we[0] = 1'b1; bus.addr[0 +: AW] = 9'h010; bus.wdata[0 +: DW] = 32'hDEADBEEF;
        bus.req[0] = 1'b1;
        @(posedge Clock);          // grant
        @(posedge Clock);          // into WAIT
        #2;
        clear = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 0);
        bus.req[0] = 1'b0;
        @(posedge Clock);
        #1;
        clear = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        exp_q.push_back('{0, 32'h0BADF00D});
        issue(0, 1'b0, 9'h010, 32'h0, l0);

        // Write then read at top address; read latency WAIT_STATES+3.
        exp_q.push_back('{0, 32'h0});
        issue(0, 1'b1, 9'h1FF, 32'h12345678, l0);
        exp_q.push_back('{0, 32'h12345678});
        issue(0, 1'b0, 9'h1FF, 32'h0, lat);
        chk("read_latency", 32'(lat), 4);

        // Contention right after reset: order 0,1,0,1 with cross-channel RAW.
        do_reset();
        exp_q.push_back('{0, 32'h0});
        exp_q.push_back('{1, 32'h0});
        exp_q.push_back('{0, 32'h22220000});
        exp_q.push_back('{1, 32'h11110000});
        fork
            begin
                issue(0, 1'b1, 9'h020, 32'h11110000, l0);
                issue(0, 1'b0, 9'h021, 32'h0, l0);
            end
            begin
                issue(1, 1'b1, 9'h021, 32'h22220000, l1);
                issue(1, 1'b0, 9'h020, 32'h0, l1);
            end
        join

        // Handshake: ch1 drops req after grant and scrambles its inputs.
        exp_q.push_back('{1, 32'h12345678});
        bus.we[1] = 1'b0; bus.addr[AW +: AW] = 9'h1FF; bus.req[1] = 1'b1;
        @(posedge Clock);
        #1;
        bus.req[1] = 1'b0; bus.we[1] = 1'b1;
        bus.addr[AW +: AW] = 9'h010; bus.wdata[DW +: DW] = 32'hFFFFFFFF;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge Clock);
            if (bus.ready[1]) got = 1;
        end
        chk("drop_req_ready", 32'(got), 1);
        bus.we[1] = 1'b0;
        repeat (6) @(posedge Clock);
        #1;
        chk("drop_req_no_regrant", 32'(bus.busy), 0);

        // Latency of the 0 and 15 wait-state builds.
        bus0.req[0] = 1'b1;
        bus15.req[0] = 1'b1;
        lat0 = 0; lat15 = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            if (lat0 == 0 && bus0.ready[0]) begin lat0 = i; bus0.req[0] = 1'b0; end
            if (lat15 == 0 && bus15.ready[0]) begin lat15 = i; bus15.req[0] = 1'b0; end
        end
        chk("latency_ws0", 32'(lat0), 3);
        chk("latency_ws15", 32'(lat15), 18);
        @(posedge Clock);
        #1;

`ifdef MEM_PRELOAD_EN
        // Preload collides with a channel COMMIT write to the same address.
        exp_q.push_back('{0, 32'h0});
        fork
            issue(0, 1'b1, 9'h000, 32'h1, l0);
            begin
                repeat (2) @(posedge Clock);
                #1;
                preload_en = 1'b1; preload_addr = 9'h000; preload_data = 32'hA5A5A5A5;
                @(posedge Clock);
                #1;
                preload_en = 1'b0;
            end
        join
        exp_q.push_back('{0, 32'hA5A5A5A5});
        issue(0, 1'b0, 9'h000, 32'h0, l0);
`endif

        repeat (4) @(posedge Clock);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
